// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin merge of N cache channels onto one slow-memory port.
//            Optional performance counters are enabled by ARB_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 51
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        ch_read,
    input  logic [NCH-1:0]        ch_write,
    input  logic [NCH*ADDR_W-1:0] ch_addr,
    input  logic [NCH*DATA_W-1:0] ch_wdata,
    output logic [DATA_W-1:0]     ch_rdata,
    output logic [NCH-1:0]        ch_ready,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic [NCH*CNT_W-1:0]  stall_cnt,
    output logic [NCH*CNT_W-1:0]  req_cnt,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic                  proto_err
);

    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    grant_q, grant_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NCH-1:0]      ready_q, ready_d;
    logic                proto_err_q, proto_err_d;

    logic [NCH-1:0]      w_pending;
    logic                w_found;
    logic [PTR_W-1:0]    w_sel;

    assign w_pending = ch_read | ch_write;

    // First pending channel at or after ptr, wrapping modulo NCH.
    always_comb begin
        logic [PTR_W-1:0] cand;
        w_found = 1'b0;
        w_sel   = ptr_q;
        cand    = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % NCH);
            if (!w_found && w_pending[cand]) begin
                w_found = 1'b1;
                w_sel   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        ready_d     = '0;
        proto_err_d = proto_err_q | (|(ch_read & ch_write));

        case (state_q)
            IDLE: begin
                if (w_found) begin
                    // Simultaneous read+write resolves to a write.
                    grant_d     = w_sel;
                    mem_write_d = ch_write[w_sel];
                    mem_read_d  = ~ch_write[w_sel];
                    mem_addr_d  = ch_addr[int'(w_sel)*ADDR_W +: ADDR_W];
                    mem_wdata_d = ch_wdata[int'(w_sel)*DATA_W +: DATA_W];
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    mem_read_d        = 1'b0;
                    mem_write_d       = 1'b0;
                    rdata_d           = mem_rdata;
                    ready_d[grant_q]  = 1'b1;
                    state_d           = RESP;
                end
            end
            RESP: begin
                ptr_d   = (grant_q == PTR_W'(NCH - 1)) ? '0 : grant_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            ready_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ch_rdata  = rdata_q;
    assign ch_ready  = ready_q;
    assign proto_err = proto_err_q;

`ifdef ARB_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NCH*CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [NCH*CNT_W-1:0] req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]     cycle_cnt_q, cycle_cnt_d;
    logic                 w_grant;

    assign w_grant = (state_q == IDLE) && w_found;

    // All counters saturate rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        req_cnt_d   = req_cnt_q;
        cycle_cnt_d = (cycle_cnt_q == CNT_MAX) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (w_pending[i] && !ready_q[i] &&
                (stall_cnt_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                stall_cnt_d[i*CNT_W +: CNT_W] = stall_cnt_q[i*CNT_W +: CNT_W] + 1'b1;
            end
            if (w_grant && (w_sel == PTR_W'(i)) &&
                (req_cnt_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                req_cnt_d[i*CNT_W +: CNT_W] = req_cnt_q[i*CNT_W +: CNT_W] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            req_cnt_q   <= '0;
            cycle_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            req_cnt_q   <= req_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign req_cnt   = req_cnt_q;
    assign cycle_cnt = cycle_cnt_q;
`else
    assign stall_cnt = '0;
    assign req_cnt   = '0;
    assign cycle_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised N-channel arbiter that merges the miss/write-back traffic of several cache channels onto one slow-memory port. It sits between the caches (L1 or L2) and the memory interface, and replaces the per-channel private memory ports. Channels are served one transaction at a time in round-robin order. Per-channel stall and request counters replace the fixed performance outputs.

## Interface
Parameters:
- NCH, 2: number of cache channels (2..8)
- ADDR_W, 28: block address width (byte address bits [31:4])
- DATA_W, 128: block data width
- CNT_W, 51: performance counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-high
- ch_read  in  NCH  per-channel read request, level, held until ch_ready
- ch_write  in  NCH  per-channel write request, level, held until ch_ready
- ch_addr  in  NCH*ADDR_W  channel i address at [i*ADDR_W +: ADDR_W]
- ch_wdata  in  NCH*DATA_W  channel i write data at [i*DATA_W +: DATA_W]
- ch_rdata  out  DATA_W  registered read data, shared; valid while the matching ch_ready bit is high
- ch_ready  out  NCH  one-cycle completion pulse, at most one bit high
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion
- stall_cnt  out  NCH*CNT_W  per-channel stall cycles
- req_cnt  out  NCH*CNT_W  per-channel granted transactions
- cycle_cnt  out  CNT_W  cycles since reset
- proto_err  out  1  sticky: a channel asserted read and write together

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: a channel is pending if ch_read|ch_write. Search starts at ptr and wraps modulo NCH. The first pending channel is granted. Grant latches op, address and wdata into registers and moves to BUSY. With no channel pending, stay in IDLE.
- BUSY: mem_read/mem_write (exactly one) and mem_addr/mem_wdata come from the registers, held stable. On mem_ready, capture mem_rdata into the ch_rdata register and move to RESP.
- RESP: ch_ready[grant]=1 for this single cycle. Set ptr=(grant+1) mod NCH. Return to IDLE.
- A channel asserting read and write together is granted as a write, and proto_err is set until reset.
- A channel that drops its request while BUSY still gets its transaction finished and its ch_ready pulse.
- mem_ready in IDLE or RESP is ignored.
- Counters saturate at all ones and never wrap:
  - stall_cnt[i] increments each cycle in which channel i has a pending request and ch_ready[i]=0.
  - req_cnt[i] increments on each grant to channel i.
  - cycle_cnt increments every cycle while rst=0.

## Timing
- Reset (async, immediate): state=IDLE, ptr=0.
- Values held in reset: mem_read=mem_write=0, mem_addr=0, mem_wdata=0, ch_rdata=0, ch_ready=0, all counters=0, proto_err=0.
- Reset asserted mid-transaction aborts the transaction. No ch_ready is issued for it.
- Request sampled in IDLE at edge 0 leads to mem strobe high from edge 1.
- mem_ready high before edge k leads to mem strobe low and ch_ready high in cycle k..k+1.
- Minimum request-to-ch_ready latency is 2 cycles plus memory latency. One idle cycle (RESP→IDLE) separates back-to-back grants.
- mem_* outputs are registered. No combinational path from inputs to outputs.

## Configuration
- ARB_PERF_CNT_EN defined: stall_cnt, req_cnt and cycle_cnt are implemented as above.
- ARB_PERF_CNT_EN undefined: counter logic is removed and the counter outputs are tied to 0. proto_err and arbitration are unaffected.

## Test plan
- Single read: NCH=2, ch_read[0]=1, addr 0x1234567, mem_ready after 3 cycles with rdata 0xA5..A5. Required: mem_read with mem_addr=0x1234567; ch_ready=2'b01 for 1 cycle with ch_rdata=0xA5..A5; req_cnt[0]=1.
- Contention: ch_read on channels 0 and 1 held continuously, NCH=2. Required: grants alternate 0,1,0,1; each channel's req_cnt=2 after 4 completions.
- Wrap: NCH=4, ptr=3, channels 0 and 2 pending. Required: channel 0 is granted first, then channel 2.
- Write plus protocol error: ch_read[1]=ch_write[1]=1 with wdata 0xDEAD..BEEF. Required: mem_write=1, mem_read=0, mem_wdata=0xDEAD..BEEF; proto_err=1 persists after completion.
- Reset mid-BUSY: assert rst while mem_read=1. Required: mem_read=0 in the same cycle; no ch_ready; all counters=0.
- Saturation: CNT_W=4, channel 0 stalled for 20 cycles. Required: stall_cnt[0] holds at 15.
